hls_run_controller: RTL and testbench
=====================================

HLS_RUN_CONTROLLER -- requirements
Module: hls_run_controller

Interface
REQ-001 Parameter NUM_RUNS, default 4, maximum number of DUT runs per session (1..65535).
REQ-002 Parameter RES_W, default 32, width of DUT result and expected value.
REQ-003 Parameter CNT_W, default 32, width of the cycle counter.
REQ-004 Parameter TIMEOUT_CYCLES, default 200000000, per-run watchdog limit; SHALL be < 2^CNT_W.
REQ-005 Port clock  input  1  sole clock; all logic on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port go  input  1  one-cycle pulse starts a session.
REQ-008 Port vec_valid / vec_ready / vec_eof  in/out/in  1 each  expected-value fetch handshake; vec_eof means no more vectors.
REQ-009 Port vec_exp  input  RES_W  expected result, captured on vec_valid && vec_ready.
REQ-010 Port dut_reset_n / dut_start_port  output  1 each  DUT reset and start.
REQ-011 Port dut_done_port / dut_result  input  1 / RES_W  DUT completion and result.
REQ-012 Port rec_valid / rec_ready  out/in  1 each  per-run record handshake.
REQ-013 Port rec_idx  output  16  zero-based run index; rec_cycles  output  CNT_W  run cycles; rec_pass / rec_cmp / rec_timeout  output  1 each  outcome flags.
REQ-014 Port busy / session_done  output  1 each  session active / one-cycle end-of-session pulse.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, DUT_RST, START, WAIT, REPORT, DONE.
REQ-016 IDLE: go=1 -> FETCH, run index cleared; go while busy=1 SHALL be ignored.
REQ-017 FETCH: vec_ready=1; vec_eof=1 -> DONE; otherwise vec_valid=1 -> capture vec_exp, go to DUT_RST. vec_eof takes priority over vec_valid.
REQ-018 DUT_RST: dut_reset_n=0 for exactly 2 cycles, then START.
REQ-019 START: dut_start_port=1 for exactly one cycle; cycle counter loaded with 1; then WAIT. If dut_done_port=1 in START, go directly to REPORT with rec_cycles=1.
REQ-020 WAIT: counter increments by 1 per cycle; on dut_done_port=1, rec_cycles = counter value in that cycle (start cycle counts as 1, done cycle included), capture dut_result, go to REPORT.
REQ-021 WAIT: counter reaching TIMEOUT_CYCLES without done -> rec_timeout=1, rec_cycles=TIMEOUT_CYCLES, rec_pass=0, REPORT; session aborts after that record.
REQ-022 REPORT: rec_valid=1 with all record fields stable until rec_ready=1; on acceptance -> FETCH if index+1 < NUM_RUNS and no timeout, else DONE.
REQ-023 DONE: session_done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-024 Counter SHALL saturate at 2^CNT_W-1, never wrap.

Reset
REQ-025 Reset SHALL force IDLE asynchronously, including mid-run; outputs: dut_reset_n=0, dut_start_port=0, vec_ready=0, rec_valid=0, busy=0, session_done=0, rec_idx=0, rec_cycles=0, all flags 0.
REQ-026 dut_reset_n SHALL be 1 in IDLE after reset release, and 0 only in DUT_RST and under reset.

Configuration
REQ-027 Macro HLS_RUN_CMP_EN defined: rec_cmp=1, rec_pass=(dut_result==captured vec_exp) && !rec_timeout.
REQ-028 Macro undefined: no comparator or expected register; rec_cmp=0, rec_pass=0; vec_exp ignored; timing unchanged.

Structure
REQ-029 Package hls_run_pkg SHALL hold the FSM state enum, the record struct type and the 16-bit run-index width constant.
REQ-030 Counter plus watchdog SHALL be sub-module hls_run_timer (load, enable, count, expired).

Verification
REQ-031 NUM_RUNS=1, done 5 cycles after start pulse, result=exp=0x2A -> rec_cycles=6, rec_pass=1, session_done one cycle after rec handshake.
REQ-032 Done asserted in START cycle -> rec_cycles=1, no WAIT visited.
REQ-033 TIMEOUT_CYCLES=10, done never -> rec_timeout=1, rec_cycles=10, rec_pass=0, session ends with NUM_RUNS=4 after one record.
REQ-034 NUM_RUNS=4, vec_eof at third FETCH -> exactly 2 records (idx 0,1), then session_done.
REQ-035 rec_ready held low 7 cycles -> record fields stable, no FETCH; result 0x2B vs exp 0x2A -> rec_pass=0 (with HLS_RUN_CMP_EN), rec_cmp=0 without it.
REQ-036 Reset asserted during WAIT -> next edge-independent IDLE, dut_start_port=0, rec_valid=0; subsequent go starts at rec_idx=0.

Source files
------------

// File: rtl/hls_run_pkg.sv
// Shared types for the HLS run controller: FSM states, per-run record layout
// and the run-index width.
package hls_run_pkg;

    localparam int unsigned RUN_IDX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DUT_RST,
        ST_START,
        ST_WAIT,
        ST_REPORT,
        ST_DONE
    } run_state_t;

    typedef struct packed {
        logic [RUN_IDX_W-1:0] idx;
        logic                 timeout;
        logic                 pass;
    } run_rec_t;

endpackage

// File: rtl/hls_run_controller_if.sv
// Expected-vector fetch and per-run record handshakes of the HLS run controller.
// master = controller side, slave = vector source / record sink.
interface hls_run_controller_if #(
    parameter int unsigned RES_W = 32,
    parameter int unsigned CNT_W = 32
);
    import hls_run_pkg::*;

    logic                 vec_valid;
    logic                 vec_ready;
    logic                 vec_eof;
    logic [RES_W-1:0]     vec_exp;

    logic                 rec_valid;
    logic                 rec_ready;
    logic [RUN_IDX_W-1:0] rec_idx;
    logic [CNT_W-1:0]     rec_cycles;
    logic                 rec_pass;
    logic                 rec_cmp;
    logic                 rec_timeout;

    modport master (
        input  vec_valid, vec_eof, vec_exp, rec_ready,
        output vec_ready, rec_valid, rec_idx, rec_cycles, rec_pass, rec_cmp, rec_timeout
    );

    modport slave (
        output vec_valid, vec_eof, vec_exp, rec_ready,
        input  vec_ready, rec_valid, rec_idx, rec_cycles, rec_pass, rec_cmp, rec_timeout
    );

endinterface

// File: rtl/hls_run_timer.sv
// Saturating per-run cycle counter with watchdog. `count` is the value of the
// current cycle (1 in the load cycle), so the cycle that sees done is included.
module hls_run_timer #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        if (load)
            count = CNT_W'(1);
        else if (cnt_q == '1)
            count = cnt_q;
        else
            count = cnt_q + CNT_W'(1);
    end

    assign expired = (count >= LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (load || enable)
            cnt_q <= count;
    end

endmodule

// File: rtl/hls_run_controller.sv
// Session controller: fetch expected value, reset/start the DUT, time it, report a record.
// Optional result comparison is built when HLS_RUN_CMP_EN is defined.
module hls_run_controller
    import hls_run_pkg::*;
#(
    parameter int unsigned NUM_RUNS       = 4,
    parameter int unsigned RES_W          = 32,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    hls_run_controller_if.master bus,
    output logic                 dut_reset_n,
    output logic                 dut_start_port,
    input  logic                 dut_done_port,
    input  logic [RES_W-1:0]     dut_result,
    output logic                 busy,
    output logic                 session_done
);

    localparam int unsigned        IW1        = RUN_IDX_W + 1;
    localparam logic [RUN_IDX_W:0] RUNS_LIMIT = IW1'(NUM_RUNS);

    run_state_t         state_q, state_d;
    run_rec_t           rec_q;
    logic [CNT_W-1:0]   cycles_q;
    logic               rst_phase_q;
    logic               dut_rst_n_q;
    logic [CNT_W-1:0]   count;
    logic               expired;
    logic               timer_load, timer_en;
    logic               run_hit, run_tmo, rec_accept, advance;
    logic               result_match;
    logic [RUN_IDX_W:0] idx_next;

    hls_run_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (timer_load),
        .enable  (timer_en),
        .count   (count),
        .expired (expired)
    );

    assign idx_next = {1'b0, rec_q.idx} + IW1'(1);
    assign advance  = (idx_next < RUNS_LIMIT) && !rec_q.timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        run_hit    = 1'b0;
        run_tmo    = 1'b0;
        rec_accept = 1'b0;
        case (state_q)
            ST_IDLE:    if (go) state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.vec_eof)
                    state_d = ST_DONE;
                else if (bus.vec_valid)
                    state_d = ST_DUT_RST;
            end
            ST_DUT_RST: if (rst_phase_q) state_d = ST_START;
            ST_START, ST_WAIT: begin
                timer_load = (state_q == ST_START);
                timer_en   = (state_q == ST_WAIT);
                // done in the limit cycle still counts as a normal completion
                if (dut_done_port) begin
                    run_hit = 1'b1;
                    state_d = ST_REPORT;
                end else if (expired) begin
                    run_tmo = 1'b1;
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_REPORT: begin
                if (bus.rec_ready) begin
                    rec_accept = 1'b1;
                    state_d    = advance ? ST_FETCH : ST_DONE;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_q       <= '0;
            cycles_q    <= '0;
            rst_phase_q <= 1'b0;
            dut_rst_n_q <= 1'b0;
        end else begin
            dut_rst_n_q <= (state_d != ST_DUT_RST);
            if (state_q == ST_IDLE && go)
                rec_q.idx <= '0;
            if (state_q == ST_FETCH)
                rst_phase_q <= 1'b0;
            else if (state_q == ST_DUT_RST)
                rst_phase_q <= 1'b1;
            if (run_hit || run_tmo) begin
                cycles_q      <= count;
                rec_q.timeout <= run_tmo;
                rec_q.pass    <= run_hit && result_match;
            end
            if (rec_accept && advance)
                rec_q.idx <= idx_next[RUN_IDX_W-1:0];
        end
    end

`ifdef HLS_RUN_CMP_EN
    logic [RES_W-1:0] exp_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            exp_q <= '0;
        else if (state_q == ST_FETCH && !bus.vec_eof && bus.vec_valid)
            exp_q <= bus.vec_exp;
    end

    assign result_match = (dut_result == exp_q);
    assign bus.rec_cmp  = 1'b1;
`else
    logic unused_cmp_inputs;

    assign unused_cmp_inputs = ^{bus.vec_exp, dut_result};
    assign result_match      = 1'b0;
    assign bus.rec_cmp       = 1'b0;
`endif

    assign bus.vec_ready   = (state_q == ST_FETCH);
    assign bus.rec_valid   = (state_q == ST_REPORT);
    assign bus.rec_idx     = rec_q.idx;
    assign bus.rec_cycles  = cycles_q;
    assign bus.rec_pass    = rec_q.pass;
    assign bus.rec_timeout = rec_q.timeout;
    assign dut_reset_n     = dut_rst_n_q;
    assign dut_start_port  = (state_q == ST_START);
    assign busy            = (state_q != ST_IDLE);
    assign session_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_hls_run_controller.sv
// Randomized bench for hls_run_controller: plans sessions of vectors with DUT
// latencies and results, predicts the record stream arithmetically, checks it.
module tb_hls_run_controller;

    localparam int unsigned NUM_RUNS = 4;
    localparam int unsigned RES_W    = 32;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned TIMEOUT  = 10;
    localparam int unsigned NEVER    = 32'hFFFF_FFFF;
    localparam int unsigned MAX_VEC  = 8;
`ifdef HLS_RUN_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    typedef struct {
        int unsigned idx;
        int unsigned cycles;
        bit          tmo;
        bit          pass;
    } exp_rec_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             go;
    logic             dut_reset_n, dut_start_port, dut_done_port;
    logic [RES_W-1:0] dut_result;
    logic             busy, session_done;

    int unsigned      n_vec = 0;
    int unsigned      n_bad = 0;
    int unsigned      plan_lat [MAX_VEC];
    logic [RES_W-1:0] plan_res [MAX_VEC];
    logic [RES_W-1:0] plan_exp [MAX_VEC];
    exp_rec_t         want [$];

    hls_run_controller_if #(.RES_W(RES_W), .CNT_W(CNT_W)) bus ();

    hls_run_controller #(
        .NUM_RUNS       (NUM_RUNS),
        .RES_W          (RES_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .go             (go),
        .bus            (bus),
        .dut_reset_n    (dut_reset_n),
        .dut_start_port (dut_start_port),
        .dut_done_port  (dut_done_port),
        .dut_result     (dut_result),
        .busy           (busy),
        .session_done   (session_done)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Record stream implied by the plan: one record per fetched vector, capped
    // by NUM_RUNS, the first timeout ends the session.
    function automatic void build_expect(input int unsigned n_avail);
        exp_rec_t r;
        want.delete();
        for (int unsigned i = 0; i < n_avail && i < NUM_RUNS; i++) begin
            r.idx    = i;
            r.tmo    = (plan_lat[i] >= TIMEOUT);
            r.cycles = r.tmo ? TIMEOUT : plan_lat[i] + 1;
            r.pass   = CMP_EN && !r.tmo && (plan_res[i] == plan_exp[i]);
            want.push_back(r);
            if (r.tmo) break;
        end
    endfunction

    task automatic set_plan(input int unsigned i, input int unsigned lat,
                            input logic [RES_W-1:0] res, input logic [RES_W-1:0] exp);
        plan_lat[i] = lat;
        plan_res[i] = res;
        plan_exp[i] = exp;
    endtask

    task automatic random_plan();
        logic [RES_W-1:0] e;
        for (int unsigned i = 0; i < MAX_VEC; i++) begin
            e = $urandom;
            case ($urandom_range(9, 0))
                0:       plan_lat[i] = NEVER;
                1:       plan_lat[i] = $urandom_range(12, 10);
                default: plan_lat[i] = $urandom_range(9, 0);
            endcase
            plan_exp[i] = e;
            plan_res[i] = ($urandom_range(1, 0) != 0) ? e : e ^ (32'h1 << $urandom_range(31, 0));
        end
    endtask

    task automatic drive_vec(input int unsigned ptr, input int unsigned n_avail);
        bus.vec_eof   = (ptr >= n_avail);
        bus.vec_valid = ($urandom_range(3, 0) != 0);
        bus.vec_exp   = (ptr < n_avail) ? plan_exp[ptr] : RES_W'($urandom);
    endtask

    // Called just after a rising edge; acts as vector source, DUT and record sink.
    task automatic run_session(input int unsigned n_avail, input int unsigned stall_lo,
                               input int unsigned stall_hi, input bit poke_go);
        int unsigned ptr = 0, k = 0, starts = 0, rst_low = 0, nrec = 0, last_evt = 0;
        int unsigned n_exp, stall;
        bit in_run = 0, fin = 0, vec_fire = 0, rec_fire = 0;
        build_expect(n_avail);
        n_exp         = want.size();
        stall         = $urandom_range(stall_hi, stall_lo);
        go            = 1'b1;
        bus.rec_ready = 1'b0;
        dut_done_port = 1'b0;
        drive_vec(ptr, n_avail);
        for (int unsigned cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clock);
            vec_fire = bus.vec_ready && bus.vec_valid && !bus.vec_eof;
            rec_fire = 1'b0;
            if (bus.vec_ready && bus.vec_eof) last_evt = cyc;
            if (!dut_reset_n) rst_low++;
            if (dut_start_port) starts++;
            if (cyc > 0) check_eq("busy_in_session", busy, 1'b1);
            if (bus.rec_valid) begin
                check_eq("fetch_during_report", bus.vec_ready, 1'b0);
                if (want.size() == 0) begin
                    check_eq("unexpected_record", bus.rec_valid, 1'b0);
                end else begin
                    check_eq("rec_idx", bus.rec_idx, want[0].idx);
                    check_eq("rec_cycles", bus.rec_cycles, want[0].cycles);
                    check_eq("rec_timeout", bus.rec_timeout, want[0].tmo);
                    check_eq("rec_pass", bus.rec_pass, want[0].pass);
                    check_eq("rec_cmp", bus.rec_cmp, CMP_EN);
                    if (bus.rec_ready) begin
                        rec_fire = 1'b1;
                        void'(want.pop_front());
                        nrec++;
                        if (want.size() == 0) last_evt = cyc;
                    end
                end
            end
            if (session_done) begin
                check_eq("done_latency", cyc - last_evt, 1);
                fin = 1'b1;
            end
            @(posedge clock);
            #1;
            go = poke_go && (cyc == 4) && !fin;
            if (vec_fire) ptr++;
            drive_vec(ptr, n_avail);
            if (rec_fire) stall = $urandom_range(stall_hi, stall_lo);
            if (bus.rec_valid) begin
                if (stall == 0) begin
                    bus.rec_ready = 1'b1;
                end else begin
                    bus.rec_ready = 1'b0;
                    stall--;
                end
            end else begin
                bus.rec_ready = ($urandom_range(1, 0) != 0);
            end
            if (!dut_reset_n || dut_done_port) in_run = 1'b0;
            if (dut_start_port) begin
                in_run = 1'b1;
                k      = 0;
            end else if (in_run) begin
                k++;
            end
            dut_done_port = in_run && (ptr > 0) && (k == plan_lat[ptr-1]);
            dut_result    = dut_done_port ? plan_res[ptr-1] : RES_W'($urandom);
        end
        go            = 1'b0;
        dut_done_port = 1'b0;
        check_eq("session_ended", fin, 1'b1);
        check_eq("records", nrec, n_exp);
        check_eq("start_pulses", starts, n_exp);
        check_eq("dut_rst_cycles", rst_low, 2 * n_exp);
        @(negedge clock);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("done_one_cycle", session_done, 1'b0);
        check_eq("idle_dut_reset_n", dut_reset_n, 1'b1);
        @(posedge clock);
        #1;
    endtask

    task automatic reset_mid_run();
        bit seen = 0;
        plan_lat[0]   = NEVER;
        bus.vec_valid = 1'b1;
        bus.vec_eof   = 1'b0;
        bus.rec_ready = 1'b0;
        dut_done_port = 1'b0;
        go            = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
        for (int unsigned i = 0; i < 20 && !seen; i++) begin
            @(posedge clock);
            #1;
            seen = dut_start_port;
        end
        check_eq("reach_start", seen, 1'b1);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_start", dut_start_port, 1'b0);
        check_eq("arst_rec_valid", bus.rec_valid, 1'b0);
        check_eq("arst_vec_ready", bus.vec_ready, 1'b0);
        check_eq("arst_dut_reset_n", dut_reset_n, 1'b0);
        check_eq("arst_rec_idx", bus.rec_idx, 0);
        check_eq("arst_rec_cycles", bus.rec_cycles, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("post_rst_dut_reset_n", dut_reset_n, 1'b1);
    endtask

    initial begin
        go            = 1'b0;
        bus.vec_valid = 1'b0;
        bus.vec_eof   = 1'b0;
        bus.vec_exp   = '0;
        bus.rec_ready = 1'b0;
        dut_done_port = 1'b0;
        dut_result    = '0;
        repeat (2) @(negedge clock);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", session_done, 1'b0);
        check_eq("rst_dut_reset_n", dut_reset_n, 1'b0);
        check_eq("rst_start", dut_start_port, 1'b0);
        check_eq("rst_vec_ready", bus.vec_ready, 1'b0);
        check_eq("rst_rec_valid", bus.rec_valid, 1'b0);
        check_eq("rst_rec_idx", bus.rec_idx, 0);
        check_eq("rst_rec_cycles", bus.rec_cycles, 0);
        check_eq("rst_flags", {bus.rec_pass, bus.rec_timeout}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("idle_dut_reset_n", dut_reset_n, 1'b1);

        // done 5 cycles after start, matching result, full NUM_RUNS session
        for (int unsigned i = 0; i < MAX_VEC; i++) set_plan(i, 5, 'h2A, 'h2A);
        run_session(4, 0, 0, 1'b0);
        // done already in the start cycle
        for (int unsigned i = 0; i < MAX_VEC; i++) set_plan(i, 0, 'h11, 'h11);
        run_session(4, 0, 2, 1'b1);
        // DUT never finishes: one timeout record ends the session
        set_plan(0, NEVER, 'h0, 'h0);
        run_session(4, 0, 1, 1'b0);
        // end-of-vectors at the third fetch
        random_plan();
        set_plan(0, 3, 'h5, 'h5);
        set_plan(1, 9, 'h6, 'h7);
        run_session(2, 0, 3, 1'b0);
        // sink holds off for 7 cycles, result mismatches
        set_plan(0, 3, 'h2B, 'h2A);
        run_session(1, 7, 7, 1'b0);

        reset_mid_run();
        random_plan();
        run_session(4, 0, 2, 1'b0);

        for (int unsigned s = 0; s < 30; s++) begin
            random_plan();
            run_session($urandom_range(6, 0), 0, 3, ($urandom_range(1, 0) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
